cpu_bus_uart: RTL



---
 rtl/cpu_bus_uart_if.sv | 12 +
 rtl/cpu_bus_uart.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_bus_uart_if.sv
// CPU byte-bus view of the UART: the CPU drives direction, address and
// write data; the peripheral returns combinational read data and a hit flag.
interface cpu_bus_uart_if;
  logic        read;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        sel;

  modport master (output read, address, wdata, input rdata, sel);
  modport slave  (input read, address, wdata, output rdata, sel);
endinterface

// File: rtl/cpu_bus_uart.sv
// Memory-mapped 8N1 UART: TX FIFO feeding a serializer, RX deserializer into
// a holding register with sticky flags, and a programmable bit divisor.
// Reads never change state; pops and flag clears happen only through writes.
module cpu_bus_uart #(
  parameter logic [15:0] BASE          = 16'hFF00,
  parameter int          TX_DEPTH_LOG2 = 2,
  parameter logic [15:0] DIV_RESET     = 16'd103
) (
  input  logic           clk,
  input  logic           rst,
  cpu_bus_uart_if.slave  bus,
  output logic           txd,
  input  logic           rxd,
  output logic           irq
);
  localparam int DEPTH = 2 ** TX_DEPTH_LOG2;
  localparam int PW    = TX_DEPTH_LOG2 + 1;
  localparam logic [PW-1:0] FULL_XOR = {1'b1, {TX_DEPTH_LOG2{1'b0}}};

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic [15:0] div;
  logic        tx_ien, tx_ovf, rx_valid, rx_ovr, rx_ferr;
  logic [7:0]  rx_data;

  logic [7:0]    fifo_mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic          fifo_empty, fifo_full, fifo_push, tx_pop;
  logic [7:0]    fifo_head;

  tx_state_t   tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic [2:0]  tx_bit, tx_bit_n;
  logic        txd_n, tx_busy;

  logic        rx_meta, rx_sync;
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_half;
  logic [7:0]  rx_shift, rx_shift_n;
  logic [2:0]  rx_bit, rx_bit_n;
  logic        rx_done;

  logic [1:0]  offset;
  logic        wr, wr_data, wr_status, clr_valid;
  logic [7:0]  status;

  assign bus.sel    = (bus.address[15:2] == BASE[15:2]);
  assign offset     = bus.address[1:0];
  assign wr         = bus.sel && !bus.read;
  assign wr_data    = wr && (offset == 2'd0);
  assign wr_status  = wr && (offset == 2'd1);
  assign clr_valid  = wr_status && bus.wdata[2];

  assign fifo_empty = (wp == rp);
  assign fifo_full  = ((wp ^ rp) == FULL_XOR);
  assign fifo_head  = fifo_mem[rp[TX_DEPTH_LOG2-1:0]];
  // A full FIFO still accepts a byte when the serializer pops on the same edge.
  assign fifo_push  = wr_data && (!fifo_full || tx_pop);

  assign tx_busy = (tx_state != TX_IDLE);
  assign status  = {tx_ien, rx_ferr, tx_busy, tx_ovf, rx_ovr, rx_valid, fifo_empty, fifo_full};
  // Half a bit period, (div+1)>>1, without needing a 17-bit intermediate.
  assign rx_half = {1'b0, div[15:1]} + {15'd0, div[0]};

  // Read mux for the system bus; zero whenever this block is not addressed.
  always_comb begin
    bus.rdata = 8'h00;
    if (bus.sel) begin
      case (offset)
        2'd0: bus.rdata = rx_data;
        2'd1: bus.rdata = status;
        2'd2: bus.rdata = div[7:0];
        2'd3: bus.rdata = div[15:8];
      endcase
    end
  end

  // FIFO pointers advance independently so push and pop can share an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (fifo_push) wp <= wp + PW'(1);
      if (tx_pop)    rp <= rp + PW'(1);
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (fifo_push) fifo_mem[wp[TX_DEPTH_LOG2-1:0]] <= bus.wdata;
  end

  // Serializer state register; txd is registered so it never glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_shift <= '0;
      tx_bit   <= '0;
      txd      <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_shift <= tx_shift_n;
      tx_bit   <= tx_bit_n;
      txd      <= txd_n;
    end
  end

  // Serializer sequencing; the counter reloads from div at every bit boundary.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_shift_n = tx_shift;
    tx_bit_n   = tx_bit;
    txd_n      = txd;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = div;
          tx_state_n = TX_START;
          txd_n      = 1'b0;
        end
      end
      TX_START: begin
        if (tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        else begin
          tx_cnt_n   = div;
          tx_bit_n   = 3'd0;
          tx_state_n = TX_DATA;
          txd_n      = tx_shift[0];
        end
      end
      TX_DATA: begin
        if (tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        else begin
          tx_cnt_n = div;
          if (tx_bit == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_cnt != 16'd0) tx_cnt_n = tx_cnt - 16'd1;
        else if (!fifo_empty) begin
          tx_pop     = 1'b1;
          tx_shift_n = fifo_head;
          tx_cnt_n   = div;
          tx_state_n = TX_START;
          txd_n      = 1'b0;
        end else begin
          tx_state_n = TX_IDLE;
          txd_n      = 1'b1;
        end
      end
    endcase
  end

  // Two-flop synchronizer for the asynchronous receive line, idling high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
    end
  end

  // Deserializer state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_shift <= '0;
      rx_bit   <= '0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_shift <= rx_shift_n;
      rx_bit   <= rx_bit_n;
    end
  end

  // Deserializer: recheck the start bit at half-bit, then sample mid-bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_shift_n = rx_shift;
    rx_bit_n   = rx_bit;
    rx_done    = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_sync) begin
          rx_cnt_n   = rx_half;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else if (!rx_sync) begin
          rx_cnt_n   = div;
          rx_bit_n   = 3'd0;
          rx_state_n = RX_DATA;
        end else rx_state_n = RX_IDLE;
      end
      RX_DATA: begin
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_cnt_n   = div;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state_n = RX_STOP;
          else rx_bit_n = rx_bit + 3'd1;
        end
      end
      RX_STOP: begin
        if (rx_cnt != 16'd0) rx_cnt_n = rx_cnt - 16'd1;
        else begin
          rx_done    = 1'b1;
          rx_state_n = RX_IDLE;
        end
      end
    endcase
  end

  // Control registers and sticky flags; a set always wins over a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      div      <= DIV_RESET;
      tx_ien   <= 1'b0;
      tx_ovf   <= 1'b0;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_data  <= 8'h00;
      irq      <= 1'b0;
    end else begin
      if (wr && offset == 2'd2) div[7:0]  <= bus.wdata;
      if (wr && offset == 2'd3) div[15:8] <= bus.wdata;
      if (wr_status) tx_ien <= bus.wdata[7];
      if (rx_done) rx_data <= rx_shift;

      if (rx_done) rx_valid <= 1'b1;
      else if (clr_valid) rx_valid <= 1'b0;

      if (rx_done && rx_valid && !clr_valid) rx_ovr <= 1'b1;
      else if (wr_status && bus.wdata[3]) rx_ovr <= 1'b0;

      if (rx_done && !rx_sync) rx_ferr <= 1'b1;
      else if (wr_status && bus.wdata[6]) rx_ferr <= 1'b0;

      if (wr_data && fifo_full && !tx_pop) tx_ovf <= 1'b1;
      else if (wr_status && bus.wdata[4]) tx_ovf <= 1'b0;

      irq <= rx_valid | (fifo_empty & tx_ien);
    end
  end
endmodule
